// File: rtl/bcd_share_ctrl_if.sv
// Bundle between the requesters, the shared-converter controller and the bcd converter.
// NREQ here must match the controller's NREQ.
interface bcd_share_ctrl_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  logic                 res_sign;
  logic [3:0]           res_hundreds;
  logic [3:0]           res_tens;
  logic [3:0]           res_ones;
  logic                 busy;
  logic [7:0]           bcd_binary;
  logic                 bcd_sign;
  logic [3:0]           bcd_hundreds;
  logic [3:0]           bcd_tens;
  logic [3:0]           bcd_ones;
  logic                 bcd_ready;

  modport slave (
    input  req, req_data, bcd_sign, bcd_hundreds, bcd_tens, bcd_ones, bcd_ready,
    output done, err, res_sign, res_hundreds, res_tens, res_ones, busy, bcd_binary
  );

  modport master (
    output req, req_data, bcd_sign, bcd_hundreds, bcd_tens, bcd_ones, bcd_ready,
    input  done, err, res_sign, res_hundreds, res_tens, res_ones, busy, bcd_binary
  );
endinterface

// File: rtl/bcd_share_ctrl.sv
// Round-robin arbiter sharing one bcd converter among NREQ requesters; latches the
// winner's value, waits for the converter, and returns the digits with a done/err pulse.
module bcd_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  bcd_share_ctrl_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);
  localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_WAIT, ST_RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id, pick, idx;
  logic           pick_vld;
  logic [TW-1:0]  timer;
  logic           timeout;

  // First requester at or above ptr, wrapping; the downward scan lets the lowest offset win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign timeout  = (timer == TLIM);
  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_vld) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.bcd_ready || timeout) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // done/err are set on the WAIT->RESP edge and cleared by default, so they are high exactly in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr              <= '0;
      id               <= '0;
      timer            <= '0;
      bus.bcd_binary   <= '0;
      bus.done         <= '0;
      bus.err          <= '0;
      bus.res_sign     <= 1'b0;
      bus.res_hundreds <= '0;
      bus.res_tens     <= '0;
      bus.res_ones     <= '0;
    end else begin
      bus.done <= '0;
      bus.err  <= '0;
      case (state)
        ST_IDLE: if (pick_vld) begin
          id             <= pick;
          bus.bcd_binary <= bus.req_data[pick];
        end
        ST_SETTLE: timer <= '0;
        ST_WAIT: begin
          // ready beats a coincident timeout
          if (bus.bcd_ready) begin
            bus.res_sign     <= bus.bcd_sign;
            bus.res_hundreds <= bus.bcd_hundreds;
            bus.res_tens     <= bus.bcd_tens;
            bus.res_ones     <= bus.bcd_ones;
            bus.done[id]     <= 1'b1;
          end else if (timeout) begin
            bus.err[id] <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: ptr <= (id == LAST) ? '0 : id + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_share_ctrl.sv
// Directed bench for bcd_share_ctrl with a behavioural converter whose ready latency is programmable.
module tb_bcd_share_ctrl;
  localparam int NREQ = 4;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_share_ctrl_if #(.NREQ(NREQ)) bus();
  bcd_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  logic rdy_en;
  int   rdy_wait;
  int   cnt;

  // cnt is 0 in LOAD, 1 in SETTLE, 2 in the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= 0;
    else if (!bus.busy) cnt <= 0;
    else                cnt <= cnt + 1;
  end

  // Converter model: during LOAD/SETTLE it shows a stale, ready result that must be ignored.
  always_comb begin
    bus.bcd_sign     = 1'b0;
    bus.bcd_hundreds = 4'(bus.bcd_binary / 100);
    bus.bcd_tens     = 4'((bus.bcd_binary / 10) % 10);
    bus.bcd_ones     = 4'(bus.bcd_binary % 10);
    bus.bcd_ready    = rdy_en && (cnt >= 2 + rdy_wait);
    if (cnt < 2) begin
      bus.bcd_sign     = 1'b1;
      bus.bcd_hundreds = 4'd9;
      bus.bcd_tens     = 4'd9;
      bus.bcd_ones     = 4'd9;
      bus.bcd_ready    = rdy_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_now();
    return {19'd0, bus.res_sign, bus.res_hundreds, bus.res_tens, bus.res_ones};
  endfunction

  // Waits (bounded) for a done/err pulse; n = negedges elapsed, -1 on expiry.
  task automatic serve(input string tag, input logic [NREQ-1:0] exp_d, input logic [NREQ-1:0] exp_e,
                       input int exp_n, input logic [31:0] exp_res);
    logic [NREQ-1:0] d, e;
    int n;
    d = '0; e = '0; n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != '0) begin
        d = bus.done; e = bus.err; n = i;
        break;
      end
    end
    chk({tag, "_done"}, 32'(d), 32'(exp_d));
    chk({tag, "_err"},  32'(e), 32'(exp_e));
    chk({tag, "_lat"},  n, exp_n);
    chk({tag, "_res"},  res_now(), exp_res);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    rdy_en       = 1'b1;
    rdy_wait     = 0;

    // reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err",  32'(bus.err), 0);
    chk("rst_res",  res_now(), 0);
    chk("rst_bin",  32'(bus.bcd_binary), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: single requester, ready on 2nd WAIT cycle; data change after latch ignored
    @(negedge clk);
    rdy_wait = 1;
    bus.req_data[0] = 8'd123;
    bus.req = 4'b0001;
    @(negedge clk);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_bin",  32'(bus.bcd_binary), 123);
    bus.req_data[0] = 8'd50;
    serve("t1", 4'b0001, 4'b0000, 4, 32'h123);
    bus.req = '0;
    @(negedge clk);
    chk("t1_pulse", 32'(bus.done), 0);
    chk("t1_idle",  32'(bus.busy), 0);
    chk("t1_hold",  32'(bus.bcd_binary), 123);

    // 2: simultaneous 1 and 2, ptr=1 -> 1 first
    rdy_wait = 0;
    bus.req_data[1] = 8'd38;
    bus.req_data[2] = 8'd200;
    bus.req = 4'b0110;
    serve("t2a", 4'b0010, 4'b0000, 4, 32'h038);
    bus.req = 4'b0100;
    serve("t2b", 4'b0100, 4'b0000, 5, 32'h200);
    bus.req = '0;

    // 4: converter never ready -> err after TO WAIT cycles, res unchanged
    @(negedge clk);
    rdy_en  = 1'b0;
    bus.req = 4'b0100;
    serve("t4", 4'b0000, 4'b0100, 3 + TO, 32'h200);
    bus.req = '0;
    @(negedge clk);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_err",  32'(bus.err), 0);

    // 6: ready on the timeout cycle -> done wins; ptr=3 so requester 3 goes
    rdy_en   = 1'b1;
    rdy_wait = TO - 1;
    bus.req_data[3] = 8'd255;
    bus.req = 4'b1000;
    serve("t6", 4'b1000, 4'b0000, 4 + TO - 1, 32'h255);
    bus.req = '0;

    // 5: reset during WAIT, then served afresh from ptr=0
    @(negedge clk);
    rdy_en = 1'b0;
    bus.req_data[1] = 8'd99;
    bus.req = 4'b0010;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_err",  32'(bus.err), 0);
    chk("t5_res",  res_now(), 0);
    chk("t5_bin",  32'(bus.bcd_binary), 0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    rdy_en   = 1'b1;
    rdy_wait = 0;
    bus.req_data[0] = 8'd7;
    bus.req = 4'b0011;
    serve("t5a", 4'b0001, 4'b0000, 4, 32'h007);
    bus.req = 4'b0010;
    serve("t5b", 4'b0010, 4'b0000, 5, 32'h099);
    bus.req = '0;

    // 3: all requesting continuously from ptr=0 -> 0,1,2,3,0
    do_reset();
    bus.req_data[0] = 8'd5;
    bus.req_data[1] = 8'd15;
    bus.req_data[2] = 8'd25;
    bus.req_data[3] = 8'd35;
    bus.req = 4'b1111;
    serve("t3_0", 4'b0001, 4'b0000, 4, 32'h005);
    serve("t3_1", 4'b0010, 4'b0000, 5, 32'h015);
    serve("t3_2", 4'b0100, 4'b0000, 5, 32'h025);
    serve("t3_3", 4'b1000, 4'b0000, 5, 32'h035);
    serve("t3_4", 4'b0001, 4'b0000, 5, 32'h005);
    bus.req = '0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
